// File: rtl/rnd_arbiter.sv
// Round-robin arbiter sharing one free-running LFSR among NUM_REQ requesters.
// Each grant advances the LFSR SHIFTS steps, then reduces the draw into
// [0, range-1] by bounded rejection sampling, falling back to range-1.
// Optional: define RND_REJECT_CNT_EN to add a saturating 16-bit reject_cnt output.
module rnd_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned LFSR_W    = 13,
   parameter int unsigned OUT_W     = 4,
   parameter int unsigned SHIFTS    = 13,
   parameter int unsigned MAX_TRIES = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*OUT_W-1:0] req_range,
   input  logic [LFSR_W-1:0]        lfsr_val,
   output logic                     lfsr_step,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [NUM_REQ-1:0]       ack,
   output logic [OUT_W-1:0]         rnd_out,
   output logic                     busy
`ifdef RND_REJECT_CNT_EN
   ,
   output logic [15:0]              reject_cnt
`endif
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(SHIFTS + 1);
   localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

   typedef enum logic [1:0] {StIdle, StShift, StCheck, StDone} state_e;

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [TRY_W-1:0]   tries_q, tries_d;
   logic [OUT_W-1:0]   rnd_q, rnd_d;

   logic [NUM_REQ-1:0] pick_oh;
   logic [PTR_W-1:0]   pick_idx;
   logic [PTR_W-1:0]   scan_ptr;
   logic               found;
   logic [OUT_W-1:0]   ranges [NUM_REQ];
   logic [OUT_W-1:0]   cand;
   logic [OUT_W-1:0]   cur_range;
   logic               req_held;
   logic               reject;

   // Split the packed range bus into per-requester bounds.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         ranges[i] = req_range[i*OUT_W +: OUT_W];
      end
   end

   assign cand      = lfsr_val[OUT_W-1:0];
   assign cur_range = ranges[ptr_q];
   assign req_held  = |(req & gnt_q);

   // Round-robin pick: first set request scanning upward from ptr_q+1, wrapping.
   always_comb begin
      pick_oh  = '0;
      pick_idx = ptr_q;
      scan_ptr = ptr_q;
      found    = 1'b0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         scan_ptr = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
         if (!found && req[scan_ptr]) begin
            found             = 1'b1;
            pick_idx          = scan_ptr;
            pick_oh[scan_ptr] = 1'b1;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         ptr_q   <= PTR_W'(NUM_REQ - 1);
         count_q <= '0;
         tries_q <= '0;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         tries_q <= tries_d;
         rnd_q   <= rnd_d;
      end
   end

   // Next-state logic, LFSR stepping and rejection sampling.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      tries_d   = tries_q;
      rnd_d     = rnd_q;
      lfsr_step = 1'b0;
      reject    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               gnt_d   = pick_oh;
               ptr_d   = pick_idx;
               count_d = '0;
               tries_d = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            lfsr_step = 1'b1;
            if (!req_held) begin
               gnt_d   = '0;
               state_d = StIdle;
            end else if (count_q == CNT_W'(SHIFTS - 1)) begin
               count_d = count_q + CNT_W'(1);
               state_d = StCheck;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         StCheck: begin
            if (!req_held) begin
               gnt_d   = '0;
               state_d = StIdle;
            end else if (cur_range == '0) begin
               rnd_d   = '0;
               state_d = StDone;
            end else if (cand < cur_range) begin
               rnd_d   = cand;
               state_d = StDone;
            end else begin
               reject  = 1'b1;
               tries_d = tries_q + TRY_W'(1);
               if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                  // Out of retries: clamp to the top of the range.
                  rnd_d   = cur_range - OUT_W'(1);
                  state_d = StDone;
               end else begin
                  lfsr_step = 1'b1;
               end
            end
         end
         StDone: begin
            gnt_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Registered outputs; ack mirrors the grant only while in DONE.
   always_comb begin
      gnt     = gnt_q;
      ack     = (state_q == StDone) ? gnt_q : '0;
      rnd_out = rnd_q;
      busy    = (state_q != StIdle);
   end

   logic unused_lfsr;
   assign unused_lfsr = ^lfsr_val;

`ifdef RND_REJECT_CNT_EN
   logic [15:0] rej_cnt_q;

   // Saturating count of CHECK rejections, fallback included.
   always_ff @(posedge clock) begin
      if (reset) begin
         rej_cnt_q <= '0;
      end else if (reject && (rej_cnt_q != 16'hFFFF)) begin
         rej_cnt_q <= rej_cnt_q + 16'd1;
      end
   end

   assign reject_cnt = rej_cnt_q;
`else
   logic unused_reject;
   assign unused_reject = reject;
`endif

endmodule

// File: tb/tb_rnd_arbiter.sv
// Directed bench for rnd_arbiter with a counting LFSR model and an
// expected-result queue popped whenever an ack appears.
module tb_rnd_arbiter;

   logic        clock;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] req_range;
   logic [12:0] lfsr_val;
   logic        lfsr_step;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic [3:0]  rnd_out;
   logic        busy;
   logic [15:0] reject_cnt;

   logic [12:0] lfsr_cnt;
   logic        force_en;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] gnt;
      logic [3:0] rnd;
      int         lat;
      int         steps;
   } exp_t;

   exp_t sb[$];

   rnd_arbiter dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .req_range (req_range),
      .lfsr_val  (lfsr_val),
      .lfsr_step (lfsr_step),
      .gnt       (gnt),
      .ack       (ack),
      .rnd_out   (rnd_out),
      .busy      (busy)
`ifdef RND_REJECT_CNT_EN
      ,
      .reject_cnt(reject_cnt)
`endif
   );

`ifndef RND_REJECT_CNT_EN
   assign reject_cnt = '0;
`endif

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // LFSR stand-in: value = number of step pulses since reset.
   always @(posedge clock) begin
      if (reset) lfsr_cnt <= '0;
      else if (lfsr_step) lfsr_cnt <= lfsr_cnt + 13'd1;
   end

   assign lfsr_val = force_en ? 13'h0FFF : lfsr_cnt;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 32'd0);
      chk({tag, "_ack"}, 32'(ack), 32'd0);
      chk({tag, "_rnd"}, 32'(rnd_out), 32'd0);
      chk({tag, "_step"}, 32'(lfsr_step), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      req      = '0;
      force_en = 1'b0;
      step();
      step();
      chk_reset_vals("reset");
      reset = 1'b0;
   endtask

   // Waits for the next ack (bounded), checking invariants on the way.
   task automatic run_txn(input string tag, input bit drop);
      exp_t e;
      int   c;
      int   steps;
      bit   got;
      e     = sb.pop_front();
      c     = 0;
      steps = 0;
      got   = 1'b0;
      while (!got && c < 60) begin
         step();
         c++;
         if (lfsr_step) steps++;
         chk({tag, "_onehot"}, 32'($onehot0(gnt)), 32'd1);
         chk({tag, "_step_idle_done"}, 32'(lfsr_step && (!busy || ack != 0)), 32'd0);
         if (c == 1) chk({tag, "_gnt_first"}, 32'(gnt), 32'(e.gnt));
         if (ack != 0) begin
            got = 1'b1;
            chk({tag, "_ack"}, 32'(ack), 32'(e.gnt));
            chk({tag, "_rnd"}, 32'(rnd_out), 32'(e.rnd));
            chk({tag, "_lat"}, 32'(c), 32'(e.lat));
            chk({tag, "_steps"}, 32'(steps), 32'(e.steps));
            if (drop) req = '0;
         end
      end
      chk({tag, "_timeout"}, 32'(got), 32'd1);
   endtask

   initial begin
      reset     = 1'b1;
      req       = '0;
      req_range = '0;
      force_en  = 1'b0;

      // 1: single request, first-try accept.
      do_reset();
      req       = 4'b0001;
      req_range = 16'h000F;
      sb.push_back('{gnt: 4'b0001, rnd: 4'd13, lat: 15, steps: 13});
      run_txn("t1", 1'b1);

      // 2: three rejections then accept of 16 -> 0.
      do_reset();
      req       = 4'b0001;
      req_range = 16'h0005;
      sb.push_back('{gnt: 4'b0001, rnd: 4'd0, lat: 18, steps: 16});
      run_txn("t2", 1'b1);
`ifdef RND_REJECT_CNT_EN
      chk("t2_reject_cnt", 32'(reject_cnt), 32'd3);
`endif

      // 3: stuck LFSR forces fallback to range-1.
      do_reset();
      force_en  = 1'b1;
      req       = 4'b0001;
      req_range = 16'h0003;
      sb.push_back('{gnt: 4'b0001, rnd: 4'd2, lat: 18, steps: 16});
      run_txn("t3", 1'b1);
`ifdef RND_REJECT_CNT_EN
      chk("t3_reject_cnt", 32'(reject_cnt), 32'd4);
`endif
      force_en = 1'b0;

      // 4: all requesting; rotation, range 0 on requester 2.
      do_reset();
      req       = 4'b1111;
      req_range = 16'hF0FF;
      sb.push_back('{gnt: 4'b0001, rnd: 4'd13, lat: 15, steps: 13});
      sb.push_back('{gnt: 4'b0010, rnd: 4'd10, lat: 15, steps: 13});
      sb.push_back('{gnt: 4'b0100, rnd: 4'd0,  lat: 15, steps: 13});
      sb.push_back('{gnt: 4'b1000, rnd: 4'd4,  lat: 15, steps: 13});
      sb.push_back('{gnt: 4'b0001, rnd: 4'd1,  lat: 15, steps: 13});
      for (int k = 0; k < 5; k++) begin
         run_txn($sformatf("t4_%0d", k), k == 4);
         step();
         chk($sformatf("t4_ack_once_%0d", k), 32'(ack), 32'd0);
         chk($sformatf("t4_idle_%0d", k), 32'(busy), 32'd0);
      end

      // 5: withdrawal during SHIFT, then 0011 goes to requester 1.
      req = 4'b0001;
      for (int c = 1; c <= 5; c++) begin
         step();
         if (c == 1) chk("t5_gnt", 32'(gnt), 32'b0001);
      end
      req = 4'b0000;
      step();
      chk("t5_abort_gnt", 32'(gnt), 32'd0);
      chk("t5_abort_busy", 32'(busy), 32'd0);
      chk("t5_abort_ack", 32'(ack), 32'd0);
      chk("t5_abort_rnd", 32'(rnd_out), 32'd1);
      req = 4'b0011;
      sb.push_back('{gnt: 4'b0010, rnd: 4'd3, lat: 15, steps: 13});
      run_txn("t5", 1'b1);

      // 6: reset during CHECK, then requester 3 wins.
      do_reset();
      req       = 4'b0001;
      req_range = 16'hF00F;
      for (int c = 1; c <= 14; c++) begin
         step();
         chk("t6_no_ack", 32'(ack), 32'd0);
      end
      chk("t6_in_check_busy", 32'(busy), 32'd1);
      chk("t6_in_check_step", 32'(lfsr_step), 32'd0);
      reset = 1'b1;
      step();
      chk_reset_vals("t6_midreset");
      reset = 1'b0;
      req   = 4'b1000;
      sb.push_back('{gnt: 4'b1000, rnd: 4'd13, lat: 15, steps: 13});
      run_txn("t6", 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rnd_arbiter.md
Name: rnd_arbiter

Overview:
- Shares the single free-running 13-bit LFSR random source among up to NUM_REQ game requesters (enemy movement, power-up drops, bomb fuse jitter).
- Round-robin arbitration; advances the LFSR by SHIFTS steps between draws for decorrelation.
- Reduces the draw to a per-requester range [0, range-1] by bounded rejection sampling.
- Returns the result with a one-cycle ack pulse.

Parameters:
- NUM_REQ, 4, number of requesters.
- LFSR_W, 13, width of the LFSR state input.
- OUT_W, 4, result and range width.
- SHIFTS, 13, LFSR steps issued per grant before the first sample (≥1).
- MAX_TRIES, 4, rejections allowed before fallback (≥1).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- req  in  NUM_REQ  level request per requester, held until ack.
- req_range  in  NUM_REQ*OUT_W  slice i = exclusive upper bound for requester i.
- lfsr_val  in  LFSR_W  current LFSR state; reflects a step on the cycle after lfsr_step.
- lfsr_step  out  1  advance enable to the LFSR, one step per high cycle.
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- ack  out  NUM_REQ  one-cycle pulse to the granted requester; rnd_out valid.
- rnd_out  out  OUT_W  result; holds until the next ack.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: gnt=0, ack=0, rnd_out=0, lfsr_step=0, busy=0, state=IDLE, tries=0, step count=0. Priority pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-transaction aborts immediately. No ack is issued.
- FSM states: IDLE, SHIFT, CHECK, DONE.
- IDLE:
  - If req≠0, grant the first set bit scanning upward (wrapping) from pointer+1.
  - Register the one-hot gnt, set pointer = granted index, clear count and tries, go to SHIFT.
- SHIFT:
  - lfsr_step=1 every cycle; count increments.
  - After SHIFTS cycles, go to CHECK.
- CHECK:
  - cand = lfsr_val[OUT_W-1:0]; r = the granted requester's range.
  - r==0 → rnd_out=0, go to DONE.
  - cand<r → rnd_out=cand, go to DONE.
  - Otherwise tries+1. If tries reaches MAX_TRIES, rnd_out=r-1 and go to DONE. Else lfsr_step=1 this cycle and stay in CHECK.
- DONE: ack=gnt for one cycle; gnt clears at the end of the cycle; return to IDLE.
- Latency (req seen in IDLE at cycle T, first-try accept):
  - gnt high T+1 .. T+SHIFTS+2.
  - lfsr_step high T+1 .. T+SHIFTS.
  - CHECK at T+SHIFTS+1.
  - ack and rnd_out at T+SHIFTS+2.
  - Each rejection adds 1 cycle.
- Withdrawal: if the granted req drops before DONE, abort to IDLE next cycle. No ack; pointer keeps its advanced value; rnd_out unchanged.
- Requesters drop req on the cycle after ack. A req still high is a new request and competes normally at the next IDLE.
- Simultaneous requests: exactly one grant. Others wait; none starves (each waits at most NUM_REQ-1 transactions).
- req_range is sampled live during CHECK and must stay stable while granted.
- lfsr_step is never high in IDLE or DONE.

Optional Feature:
- Macro RND_REJECT_CNT_EN.
- Defined: adds output port reject_cnt (16 bits). It increments once per CHECK rejection, including the one that triggers fallback, saturates at 0xFFFF, and clears on reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
Bench LFSR model returns lfsr_val = count of step pulses since reset unless stated. Parameters are defaults.
1. Reset, then req=0001, range0=15:
   - gnt=0001 at cycle 1; 13 step pulses.
   - CHECK sees 13; ack=0001 at cycle 15 with rnd_out=13.
2. After reset, req=0001, range0=5:
   - 13, 14, 15 rejected; 16 accepted.
   - ack at cycle 18 with rnd_out=0; reject_cnt=3 if RND_REJECT_CNT_EN.
3. lfsr_val forced to 0xFFF, range=3:
   - 4 rejections, then fallback rnd_out=2.
   - 3 extra step pulses in CHECK; ack 4 cycles after CHECK entry.
4. req=1111 held continuously:
   - Grants in order 0001, 0010, 0100, 1000, 0001.
   - Exactly one ack per transaction; gnt always one-hot.
5. req0 dropped at cycle 5 of SHIFT:
   - Return to IDLE next cycle; no ack; rnd_out unchanged.
   - Next req=0011 is granted to requester 1.
6. Reset asserted during CHECK:
   - All outputs return to their reset values the next cycle.
   - Next req=1000 is granted to requester 3 after a full SHIFTS sequence.
